// File: rtl/fx_reverb_comb.sv
// fx_reverb_comb: multi-channel damped feedback comb reverb sharing one delay RAM, with dry/wet mix.
// Ports: clk, reset (sync, active-high); sample_en strobes audio_in and fx_size/fx_damping/fx_mix in;
// audio_out/out_valid deliver each processed frame; busy is high outside IDLE; overrun flags a dropped strobe.
module fx_reverb_comb #(
  parameter int DATA_W   = 16,
  parameter int PARAM_W  = 8,
  parameter int N_CH     = 2,
  parameter int DELAY_AW = 10,
  parameter int FEEDBACK = 179
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_en,
  input  logic [N_CH-1:0][DATA_W-1:0] audio_in,
  input  logic [PARAM_W-1:0]          fx_size,
  input  logic [PARAM_W-1:0]          fx_damping,
  input  logic [PARAM_W-1:0]          fx_mix,
  output logic [N_CH-1:0][DATA_W-1:0] audio_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        overrun
);
  localparam int CH_W  = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int AW    = CH_W + DELAY_AW;
  localparam int DEPTH = N_CH << DELAY_AW;
  localparam int PW    = DATA_W + PARAM_W + 2;
  localparam int LW    = PARAM_W + DELAY_AW + 1;
  localparam logic signed [PARAM_W:0] FB = (PARAM_W+1)'(FEEDBACK);
  localparam logic signed [PW-1:0] SAT_HI = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_CALC, S_WR, S_DONE} state_t;
  function automatic logic [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
    return v > SAT_HI ? SAT_HI[DATA_W-1:0] : v < SAT_LO ? SAT_LO[DATA_W-1:0] : v[DATA_W-1:0];
  endfunction
  state_t                      state_q, state_d;
  logic [AW-1:0]               clr_q, clr_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [DELAY_AW-1:0]         wr_ptr_q, wr_ptr_d, len_q, len_d;
  logic [PARAM_W-1:0]          damp_q, damp_d, mix_q, mix_d;
  logic [N_CH-1:0][DATA_W-1:0] x_q, x_d, lp_q, lp_d, y_q, y_d, out_q, out_d;
  logic [DATA_W-1:0]           w_q, w_d, rd_q, wdata;
  logic                        out_valid_q, out_valid_d, overrun_q, overrun_d, we;
  logic [AW-1:0]               waddr, rd_addr;
  logic [DATA_W-1:0]           mem [DEPTH];
  logic [DELAY_AW:0]           len_c;
  logic signed [DATA_W-1:0]    d, xs, lp_new;
  logic signed [PW-1:0]        p_lp, p_fb, p_mix, w_sum, y_sum;
  // len = ((size+1) * 2^DELAY_AW) >> PARAM_W; a full-depth length aliases to 0 mod 2^DELAY_AW,
  // which makes the read address equal wr_ptr, i.e. the oldest word before it is overwritten.
  assign len_c   = (DELAY_AW+1)'(((LW'(fx_size) + LW'(1)) << DELAY_AW) >> PARAM_W);
  assign rd_addr = {ch_q, wr_ptr_q - len_q};
  assign d       = rd_q;
  assign xs      = x_q[ch_q];
  assign p_lp    = ($signed(lp_q[ch_q]) - d) * $signed({1'b0, damp_q});
  // lp_new lies between d and lp, so truncating back to DATA_W is lossless
  assign lp_new  = DATA_W'(d + (p_lp >>> PARAM_W));
  assign p_fb    = lp_new * FB;
  assign w_sum   = xs + (p_fb >>> PARAM_W);
  assign p_mix   = (lp_new - xs) * $signed({1'b0, mix_q});
  assign y_sum   = xs + (p_mix >>> PARAM_W);
  assign busy      = state_q != S_IDLE;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign audio_out = out_q;
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    ch_d        = ch_q;
    wr_ptr_d    = wr_ptr_q;
    len_d       = len_q;
    damp_d      = damp_q;
    mix_d       = mix_q;
    x_d         = x_q;
    lp_d        = lp_q;
    y_d         = y_q;
    out_d       = out_q;
    w_d         = w_q;
    out_valid_d = 1'b0;
    overrun_d   = sample_en && state_q != S_IDLE;
    we          = 1'b0;
    waddr       = {ch_q, wr_ptr_q};
    wdata       = w_q;
    case (state_q)
      S_CLEAR: begin
        we      = 1'b1;
        waddr   = clr_q;
        wdata   = '0;
        clr_d   = clr_q + 1'b1;
        state_d = clr_q == AW'(DEPTH-1) ? S_IDLE : S_CLEAR;
      end
      S_IDLE: if (sample_en) begin
        x_d     = audio_in;
        len_d   = len_c == '0 ? DELAY_AW'(1) : DELAY_AW'(len_c);
        damp_d  = fx_damping;
        mix_d   = fx_mix;
        ch_d    = '0;
        state_d = S_RD;
      end
      S_RD: state_d = S_CALC;
      S_CALC: begin
        lp_d[ch_q] = lp_new;
        w_d        = sat(w_sum);
        y_d[ch_q]  = sat(y_sum);
        state_d    = S_WR;
      end
      S_WR: begin
        we      = 1'b1;
        ch_d    = ch_q + 1'b1;
        state_d = ch_q == CH_W'(N_CH-1) ? S_DONE : S_RD;
      end
      S_DONE: begin
        out_d       = y_q;
        out_valid_d = 1'b1;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clr_q       <= '0;
      ch_q        <= '0;
      wr_ptr_q    <= '0;
      len_q       <= '0;
      damp_q      <= '0;
      mix_q       <= '0;
      x_q         <= '0;
      lp_q        <= '0;
      y_q         <= '0;
      out_q       <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      ch_q        <= ch_d;
      wr_ptr_q    <= wr_ptr_d;
      len_q       <= len_d;
      damp_q      <= damp_d;
      mix_q       <= mix_d;
      x_q         <= x_d;
      lp_q        <= lp_d;
      y_q         <= y_d;
      out_q       <= out_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we && !reset) mem[waddr] <= wdata;
    rd_q <= mem[rd_addr];
  end
endmodule

// File: tb/tb_fx_reverb_comb.sv
// tb_fx_reverb_comb: directed + randomized bench for fx_reverb_comb against a per-channel delay-line model.
module tb_fx_reverb_comb;
  localparam int DW = 16, PW = 8, NC = 2, DA = 4, FB = 128, DEP = 16;
  logic clk = 1'b0, reset = 1'b1, sample_en = 1'b0;
  logic [NC-1:0][DW-1:0] audio_in = '0;
  logic [PW-1:0] fx_size = '0, fx_damping = '0, fx_mix = '0;
  logic [NC-1:0][DW-1:0] audio_out;
  logic out_valid, busy, overrun;
  int n_vec = 0, n_fail = 0;
  int dl [NC][DEP];
  int lp [NC];
  int wp;
  int exp_y [NC];
  fx_reverb_comb #(.DATA_W(DW), .PARAM_W(PW), .N_CH(NC), .DELAY_AW(DA), .FEEDBACK(FB)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .audio_in(audio_in),
    .fx_size(fx_size), .fx_damping(fx_damping), .fx_mix(fx_mix),
    .audio_out(audio_out), .out_valid(out_valid), .busy(busy), .overrun(overrun));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int fdiv256(input int a);
    int q = a / 256;
    if (a % 256 != 0 && a < 0) q--;
    return q;
  endfunction
  function automatic int sat16(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  function automatic int rnd16();
    logic [15:0] r = 16'($urandom);
    return int'($signed(r));
  endfunction
  function automatic int out_ch(input int c);
    return int'($signed(audio_out[c]));
  endfunction
  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      lp[c] = 0;
      for (int i = 0; i < DEP; i++) dl[c][i] = 0;
    end
    wp = 0;
  endtask
  task automatic model_frame(input int x0, input int x1);
    int xs [NC];
    int len, dv, lpn, w;
    xs[0] = x0;
    xs[1] = x1;
    len = ((int'(fx_size) + 1) * DEP) / 256;
    if (len < 1) len = 1;
    for (int c = 0; c < NC; c++) begin
      dv       = dl[c][(wp - len + DEP) % DEP];
      lpn      = dv + fdiv256((lp[c] - dv) * int'(fx_damping));
      w        = sat16(xs[c] + fdiv256(lpn * FB));
      exp_y[c] = sat16(xs[c] + fdiv256((lpn - xs[c]) * int'(fx_mix)));
      lp[c]    = lpn;
      dl[c][wp] = w;
    end
    wp = (wp + 1) % DEP;
  endtask
  task automatic do_reset(input bit strobe);
    int n = 0;
    bit quiet = 1'b1;
    reset = 1'b1;
    sample_en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    check("rst_out0", out_ch(0), 0);
    check("rst_out1", out_ch(1), 0);
    check("rst_busy", int'(busy), 1);
    reset = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      if (strobe && n == 5) sample_en = 1'b1;
      @(posedge clk); #1;
      n++;
      if (sample_en) begin
        sample_en = 1'b0;
        check("clear_overrun", int'(overrun), 1);
      end
      if (out_valid !== 1'b0 || audio_out !== '0) quiet = 1'b0;
    end
    check("clear_cycles", n, 32);
    check("clear_quiet", int'(quiet), 1);
    model_reset();
  endtask
  task automatic do_frame(input int x0, input int x1, input int ovr_at);
    int lat = 0;
    bit seen = 1'b0;
    audio_in[0] = 16'(x0);
    audio_in[1] = 16'(x1);
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    model_frame(x0, x1);
    while (!seen && lat < 20) begin
      if (lat + 1 == ovr_at) begin
        sample_en = 1'b1;
        audio_in = {16'($urandom), 16'($urandom)};
        fx_mix = fx_mix + 8'd77;
      end
      @(posedge clk); #1;
      lat++;
      if (sample_en) begin
        sample_en = 1'b0;
        check("overrun", int'(overrun), 1);
      end
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("latency", lat, 7);
    check("out_ch0", out_ch(0), exp_y[0]);
    check("out_ch1", out_ch(1), exp_y[1]);
  endtask
  initial begin
    int x0, x1;
    do_reset(1'b0);
    fx_mix = '0;
    for (int f = 0; f < 8; f++) begin
      x0 = rnd16();
      x1 = rnd16();
      fx_size = 8'($urandom);
      fx_damping = 8'($urandom);
      do_frame(x0, x1, 0);
      check("dry_ch0", out_ch(0), x0);
      check("dry_ch1", out_ch(1), x1);
    end
    for (int f = 0; f < 10; f++) begin
      fx_size = 8'($urandom);
      fx_damping = 8'($urandom);
      fx_mix = 8'($urandom);
      do_frame(rnd16(), rnd16(), 0);
    end
    do_reset(1'b0);
    fx_size = 8'd63;
    fx_damping = '0;
    fx_mix = 8'd255;
    for (int f = 0; f < 12; f++) begin
      do_frame(f == 0 ? 16384 : 0, 0, 0);
      check("imp_ch0", out_ch(0), f == 0 ? 64 : f == 4 ? 16320 : f == 8 ? 8160 : 0);
      check("imp_ch1", out_ch(1), 0);
    end
    fx_size = '0;
    for (int f = 0; f < 8; f++) begin
      do_frame(32767, 32767, 0);
      check("sat_pos0", int'($signed(audio_out[0]) >= 0), 1);
      check("sat_pos1", int'($signed(audio_out[1]) >= 0), 1);
      if (f > 0) check("sat_top0", out_ch(0), 32767);
    end
    fx_size = 8'd20;
    fx_damping = 8'd50;
    fx_mix = 8'd200;
    do_frame(rnd16(), rnd16(), 3);
    do_frame(rnd16(), rnd16(), 0);
    do_frame(rnd16(), rnd16(), 0);
    fx_size = 8'd63;
    fx_damping = '0;
    fx_mix = 8'd255;
    audio_in[0] = 16'h4000;
    audio_in[1] = 16'h0000;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    do_reset(1'b1);
    for (int f = 0; f < 12; f++) begin
      do_frame(0, 0, 0);
      check("no_echo0", out_ch(0), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
